// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the lab-datapath control FSM: opcodes, state encodings,
// the control-word layout and small decode helpers.
package dp_ctrl_pkg;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_MV   = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_DISP = 4'b0100;
    localparam logic [3:0] OP_SUBI = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_ADDN = 4'b1000;
    localparam logic [3:0] OP_SUBN = 4'b1001;

    typedef enum logic [4:0] {
        S_IDLE = 5'd0,
        S_LOAD = 5'd1,
        S_MV   = 5'd2,
        S_RDX  = 5'd3,
        S_OPY  = 5'd4,
        S_OPI  = 5'd5,
        S_WB   = 5'd6,
        S_DISP = 5'd7,
        S_G2A  = 5'd8,
        S_ILL  = 5'd9,
        S_DONE = 5'd10
    } state_e;

    typedef struct packed {
        logic extern_o;
        logic gout;
        logic iout;
        logic ain;
        logic gin;
        logic dpin;
        logic rdx;
        logic rdy;
        logic wrx;
        logic add_sub;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{default: 1'b0};

    function automatic logic is_repeat_op(input logic [3:0] op);
        return (op == OP_ADDN) || (op == OP_SUBN);
    endfunction

    function automatic logic is_imm_op(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    // First state after accept; a zero repeat count skips the datapath entirely.
    function automatic state_e entry_state(input logic [3:0] op, input logic cnt_zero);
        state_e s;
        case (op)
            OP_LOAD:                          s = S_LOAD;
            OP_MV:                            s = S_MV;
            OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: s = S_RDX;
            OP_DISP:                          s = S_DISP;
            OP_ADDN, OP_SUBN:                 s = cnt_zero ? S_DONE : S_RDX;
            default:                          s = S_ILL;
        endcase
        return s;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_e s, input logic [3:0] op);
        ctrl_t c;
        c = CTRL_NONE;
        case (s)
            S_LOAD: begin c.extern_o = 1'b1; c.wrx = 1'b1; end
            S_MV:   begin c.rdy = 1'b1; c.wrx = 1'b1; end
            S_RDX:  begin c.rdx = 1'b1; c.ain = 1'b1; end
            S_OPY:  begin
                c.rdy     = 1'b1;
                c.gin     = 1'b1;
                c.add_sub = (op == OP_SUB) || (op == OP_SUBN);
            end
            S_OPI:  begin
                c.iout    = 1'b1;
                c.gin     = 1'b1;
                c.add_sub = (op == OP_SUBI);
            end
            S_WB:   begin c.gout = 1'b1; c.wrx = 1'b1; end
            S_DISP: begin c.rdx = 1'b1; c.dpin = 1'b1; end
            S_G2A:  begin c.gout = 1'b1; c.ain = 1'b1; end
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dp_ctrl_fsm_rep_counter.sv
// Repeat counter for ADDN/SUBN: loads the count on accept, steps down once per
// extra accumulation, and flags when the current pass is the last one.
module rep_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_last
);

    logic [CNT_W-1:0] rem_q, rem_d;

    // Load takes priority; decrement never wraps below zero.
    always_comb begin
        rem_d = rem_q;
        if (load) begin
            rem_d = load_val;
        end else if (dec && (rem_q != {CNT_W{1'b0}})) begin
            rem_d = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            rem_d = rem_q;
        end
    end

    // Remaining-pass register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= {CNT_W{1'b0}};
        end else begin
            rem_q <= rem_d;
        end
    end

    assign is_last = (rem_q <= {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/dp_ctrl_fsm.sv
// Control FSM for the lab datapath: accepts an instruction on execute, issues one
// control word per cycle, then holds done until execute drops.
module dp_ctrl_fsm
    import dp_ctrl_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              execute,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] rx,
    input  logic [ADDR_W-1:0] ry,
    input  logic [CNT_W-1:0]  count,
    output logic              Extern,
    output logic              Gout,
    output logic              Iout,
    output logic              Ain,
    output logic              Gin,
    output logic              DPin,
    output logic              RdX,
    output logic              RdY,
    output logic              WrX,
    output logic              add_sub,
    output logic [ADDR_W-1:0] AddrX,
    output logic [ADDR_W-1:0] AddrY,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [4:0]        cur_state
);

    state_e            state_q, state_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [ADDR_W-1:0] rx_q, rx_d;
    logic [ADDR_W-1:0] ry_q, ry_d;
    logic              illegal_q, illegal_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              accept_s;
    logic              rem_dec_s;
    logic              rem_last_s;

    rep_counter #(.CNT_W(CNT_W)) u_rep_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept_s),
        .load_val (count),
        .dec      (rem_dec_s),
        .is_last  (rem_last_s)
    );

    // Instruction latch and sticky illegal flag.
    always_comb begin
        accept_s  = (state_q == S_IDLE) && execute;
        opcode_d  = accept_s ? opcode : opcode_q;
        rx_d      = accept_s ? rx : rx_q;
        ry_d      = accept_s ? ry : ry_q;
        illegal_d = illegal_q;
        if (accept_s) begin
            illegal_d = 1'b0;
        end else if (state_q == S_ILL) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Next-state logic; the counter steps down on each OPY -> G2A loop-back.
    always_comb begin
        state_d   = state_q;
        rem_dec_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (execute) begin
                    state_d = entry_state(opcode, count == {CNT_W{1'b0}});
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD, S_MV, S_DISP, S_ILL, S_WB: state_d = S_DONE;
            S_RDX: state_d = is_imm_op(opcode_q) ? S_OPI : S_OPY;
            S_OPI: state_d = S_WB;
            S_OPY: begin
                if (is_repeat_op(opcode_q) && !rem_last_s) begin
                    state_d   = S_G2A;
                    rem_dec_s = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_G2A: state_d = S_OPY;
            S_DONE: begin
                if (execute) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        ctrl_d = decode_ctrl(state_d, opcode_d);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, latch and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opcode_q  <= 4'b0000;
            rx_q      <= {ADDR_W{1'b0}};
            ry_q      <= {ADDR_W{1'b0}};
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ctrl_q    <= CTRL_NONE;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign Extern    = ctrl_q.extern_o;
    assign Gout      = ctrl_q.gout;
    assign Iout      = ctrl_q.iout;
    assign Ain       = ctrl_q.ain;
    assign Gin       = ctrl_q.gin;
    assign DPin      = ctrl_q.dpin;
    assign RdX       = ctrl_q.rdx;
    assign RdY       = ctrl_q.rdy;
    assign WrX       = ctrl_q.wrx;
    assign add_sub   = ctrl_q.add_sub;
    assign AddrX     = rx_q;
    assign AddrY     = ry_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign cur_state = state_q;

endmodule

// File: tb/tb_dp_ctrl_fsm.sv
// Self-checking bench for dp_ctrl_fsm: directed scenarios plus random instructions
// compared against a per-instruction expected control-word sequence.
module tb_dp_ctrl_fsm;

    localparam int ADDR_W = 2;
    localparam int CNT_W  = 4;

    // Control word bit layout used by the bench: {Extern,Gout,Iout,Ain,Gin,DPin,RdX,RdY,WrX,add_sub}
    localparam logic [9:0] C_EXT  = 10'b1000000000;
    localparam logic [9:0] C_GOUT = 10'b0100000000;
    localparam logic [9:0] C_IOUT = 10'b0010000000;
    localparam logic [9:0] C_AIN  = 10'b0001000000;
    localparam logic [9:0] C_GIN  = 10'b0000100000;
    localparam logic [9:0] C_DPIN = 10'b0000010000;
    localparam logic [9:0] C_RDX  = 10'b0000001000;
    localparam logic [9:0] C_RDY  = 10'b0000000100;
    localparam logic [9:0] C_WRX  = 10'b0000000010;
    localparam logic [9:0] C_SUB  = 10'b0000000001;
    localparam logic [9:0] C_NONE = 10'b0000000000;

    logic clk = 1'b0;
    logic reset, execute;
    logic [3:0] opcode;
    logic [ADDR_W-1:0] rx, ry;
    logic [CNT_W-1:0] count;
    logic Extern, Gout, Iout, Ain, Gin, DPin, RdX, RdY, WrX, add_sub;
    logic [ADDR_W-1:0] AddrX, AddrY;
    logic busy, done, illegal;
    logic [4:0] cur_state;
    logic [9:0] ctrl_obs;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign ctrl_obs = {Extern, Gout, Iout, Ain, Gin, DPin, RdX, RdY, WrX, add_sub};

    dp_ctrl_fsm #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .execute(execute), .opcode(opcode),
        .rx(rx), .ry(ry), .count(count),
        .Extern(Extern), .Gout(Gout), .Iout(Iout), .Ain(Ain), .Gin(Gin),
        .DPin(DPin), .RdX(RdX), .RdY(RdY), .WrX(WrX), .add_sub(add_sub),
        .AddrX(AddrX), .AddrY(AddrY), .busy(busy), .done(done),
        .illegal(illegal), .cur_state(cur_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected per-cycle control words between accept and DONE, built from the opcode table.
    task automatic build_expect(input logic [3:0] op, input logic [3:0] cnt,
                                output logic [9:0] q[$], output bit ill);
        q   = {};
        ill = 1'b0;
        case (op)
            4'b0000: q.push_back(C_EXT | C_WRX);
            4'b0001: q.push_back(C_RDY | C_WRX);
            4'b0011, 4'b0010: begin
                q.push_back(C_RDX | C_AIN);
                q.push_back(C_RDY | C_GIN | ((op == 4'b0010) ? C_SUB : C_NONE));
                q.push_back(C_GOUT | C_WRX);
            end
            4'b0111, 4'b0110: begin
                q.push_back(C_RDX | C_AIN);
                q.push_back(C_IOUT | C_GIN | ((op == 4'b0110) ? C_SUB : C_NONE));
                q.push_back(C_GOUT | C_WRX);
            end
            4'b0100: q.push_back(C_RDX | C_DPIN);
            4'b1000, 4'b1001: begin
                if (cnt != 4'd0) begin
                    q.push_back(C_RDX | C_AIN);
                    for (int i = 0; i < int'(cnt); i++) begin
                        q.push_back(C_RDY | C_GIN | ((op == 4'b1001) ? C_SUB : C_NONE));
                        if (i < int'(cnt) - 1) q.push_back(C_GOUT | C_AIN);
                    end
                    q.push_back(C_GOUT | C_WRX);
                end
            end
            default: begin
                q.push_back(C_NONE);
                ill = 1'b1;
            end
        endcase
    endtask

    // Issue one instruction from IDLE (caller at a negedge) and check every cycle to IDLE.
    task automatic run_instr(input logic [3:0] op, input logic [ADDR_W-1:0] r_x,
                             input logic [ADDR_W-1:0] r_y, input logic [3:0] cnt,
                             input int hold, input logic [3:0] post_op);
        logic [9:0] exp_q[$];
        bit ill;
        build_expect(op, cnt, exp_q, ill);
        opcode = op; rx = r_x; ry = r_y; count = cnt; execute = 1'b1;
        @(negedge clk);
        opcode = post_op; rx = ~r_x; ry = ~r_y; count = ~cnt;
        foreach (exp_q[i]) begin
            chk($sformatf("ctrl op%0h step%0d", op, i), 32'(ctrl_obs), 32'(exp_q[i]));
            chk("busy_work", 32'(busy), 32'd1);
            chk("done_work", 32'(done), 32'd0);
            chk("illegal_work", 32'(illegal), 32'd0);
            chk("addrx_work", 32'(AddrX), 32'(r_x));
            chk("addry_work", 32'(AddrY), 32'(r_y));
            @(negedge clk);
        end
        chk($sformatf("done_enter op%0h", op), 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd1);
        chk("ctrl_done", 32'(ctrl_obs), 32'(C_NONE));
        chk("illegal_done", 32'(illegal), 32'(ill));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("done_hold", 32'(done), 32'd1);
            chk("ctrl_hold", 32'(ctrl_obs), 32'(C_NONE));
        end
        execute = 1'b0;
        @(negedge clk);
        chk("done_exit", 32'(done), 32'd0);
        chk("busy_exit", 32'(busy), 32'd0);
        chk("ctrl_idle", 32'(ctrl_obs), 32'(C_NONE));
        chk("illegal_sticky", 32'(illegal), 32'(ill));
        @(negedge clk);
        chk("busy_no_retrigger", 32'(busy), 32'd0);
        chk("ctrl_no_retrigger", 32'(ctrl_obs), 32'(C_NONE));
    endtask

    initial begin
        reset = 1'b1; execute = 1'b0; opcode = 4'd0; rx = '0; ry = '0; count = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 32'(ctrl_obs), 32'(C_NONE));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_addrx", 32'(AddrX), 32'd0);
        chk("rst_addry", 32'(AddrY), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of ADD, while in OPY.
        opcode = 4'b0011; rx = 2'd1; ry = 2'd3; count = 4'd0; execute = 1'b1;
        @(negedge clk);
        chk("abort_rdx", 32'(ctrl_obs), 32'(C_RDX | C_AIN));
        @(negedge clk);
        chk("abort_opy", 32'(ctrl_obs), 32'(C_RDY | C_GIN));
        reset = 1'b1; execute = 1'b0;
        @(negedge clk);
        chk("abort_ctrl", 32'(ctrl_obs), 32'(C_NONE));
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_addrx", 32'(AddrX), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_wrx", 32'(WrX), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);

        run_instr(4'b0000, 2'd2, 2'd0, 4'd0, 2, 4'b0011);   // LOAD rx=2
        run_instr(4'b0011, 2'd1, 2'd3, 4'd0, 0, 4'b0100);   // ADD, opcode flips to DISP
        run_instr(4'b0010, 2'd3, 2'd2, 4'd0, 0, 4'b0000);   // SUB
        run_instr(4'b0111, 2'd0, 2'd1, 4'd0, 1, 4'b0000);   // ADDI
        run_instr(4'b0110, 2'd2, 2'd1, 4'd0, 0, 4'b0000);   // SUBI
        run_instr(4'b0001, 2'd1, 2'd2, 4'd0, 0, 4'b0000);   // MV
        run_instr(4'b0100, 2'd3, 2'd0, 4'd0, 0, 4'b0000);   // DISP
        run_instr(4'b1000, 2'd1, 2'd2, 4'd3, 0, 4'b0000);   // ADDN x3
        run_instr(4'b1000, 2'd2, 2'd3, 4'd0, 0, 4'b0000);   // ADDN x0
        run_instr(4'b1001, 2'd0, 2'd3, 4'd15, 0, 4'b0000);  // SUBN x15
        run_instr(4'b1001, 2'd3, 2'd1, 4'd1, 0, 4'b1111);   // SUBN x1
        run_instr(4'b1111, 2'd1, 2'd1, 4'd0, 0, 4'b0000);   // illegal
        run_instr(4'b0000, 2'd3, 2'd0, 4'd0, 5, 4'b1111);   // LOAD clears illegal, long hold

        for (int n = 0; n < 30; n++) begin
            run_instr(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom),
                      4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
